// File: rtl/reg_memoria_pkg.sv
// rtl/reg_memoria_pkg.sv - shared edge-select constants and width helper for the memory data-path pipe
package reg_memoria_pkg;

  localparam int EDGE_POS = 0;
  localparam int EDGE_NEG = 1;

  // Smallest w with 2**w >= value; used to size the occupancy count.
  function automatic int clog2(input int value);
    int width;
    width = 0;
    while ((1 << width) < value) width++;
    return width;
  endfunction

endpackage

// File: rtl/reg_memoria_stage.sv
// rtl/reg_memoria_stage.sv - one valid+data register pair of the elastic memory pipe
module reg_memoria_stage
  import reg_memoria_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int NEG_EDGE = EDGE_NEG
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             clear,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  logic             valid_d, valid_q;
  logic [WIDTH-1:0] data_d, data_q;

  // Data only moves when a real word arrives; a flush leaves data untouched.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clear) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = up_valid;
      if (up_valid) data_d = up_data;
    end
  end

  generate
    if (NEG_EDGE == EDGE_NEG) begin : g_neg
      always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
          valid_q <= 1'b0;
          data_q  <= '0;
        end else begin
          valid_q <= valid_d;
          data_q  <= data_d;
        end
      end
    end else begin : g_pos
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          valid_q <= 1'b0;
          data_q  <= '0;
        end else begin
          valid_q <= valid_d;
          data_q  <= data_d;
        end
      end
    end
  endgenerate

  assign valid = valid_q;
  assign data  = data_q;

endmodule

// File: rtl/reg_memoria_pipe.sv
// rtl/reg_memoria_pipe.sv - elastic multi-stage pipeline register with bubble collapsing, flush and occupancy count
module reg_memoria_pipe
  import reg_memoria_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 2,
  parameter int NEG_EDGE = EDGE_NEG,
  parameter int CW       = clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    count
);

  logic [DEPTH-1:0] stage_valid;
  logic [DEPTH-1:0] stage_ready;
  logic [DEPTH-1:0] up_valid;
  logic [WIDTH-1:0] stage_data [DEPTH];
  logic [WIDTH-1:0] up_data    [DEPTH];
  logic [CW-1:0]    count_d, count_q;
  logic             push;
  logic             pop;

  // A stage may load whenever it or anything downstream of it has room to move.
  always_comb begin : ready_chain
    logic downstream;
    downstream  = out_ready;
    stage_ready = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      stage_ready[i] = !stage_valid[i] || downstream;
      downstream     = stage_ready[i];
    end
  end

  always_comb begin
    up_valid    = '0;
    up_valid[0] = in_valid;
    up_data[0]  = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      up_valid[i] = stage_valid[i-1];
      up_data[i]  = stage_data[i-1];
    end
  end

  generate
    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
      reg_memoria_stage #(
        .WIDTH    (WIDTH),
        .NEG_EDGE (NEG_EDGE)
      ) u_stage (
        .clk      (clk),
        .reset    (reset),
        .load     (stage_ready[g]),
        .clear    (flush),
        .up_valid (up_valid[g]),
        .up_data  (up_data[g]),
        .valid    (stage_valid[g]),
        .data     (stage_data[g])
      );
    end
  endgenerate

  assign in_ready  = stage_ready[0] && !flush;
  assign out_valid = stage_valid[DEPTH-1];
  assign out_data  = stage_data[DEPTH-1];

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  // A pop during flush is still consumed; flush simply zeroes the count.
  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
  end

  generate
    if (NEG_EDGE == EDGE_NEG) begin : g_cnt_neg
      always_ff @(negedge clk or posedge reset) begin
        if (reset) count_q <= '0;
        else       count_q <= count_d;
      end
    end else begin : g_cnt_pos
      always_ff @(posedge clk or posedge reset) begin
        if (reset) count_q <= '0;
        else       count_q <= count_d;
      end
    end
  endgenerate

  assign count = count_q;

endmodule

// File: tb/tb_reg_memoria_pipe.sv
// tb/tb_reg_memoria_pipe.sv - self-checking bench for reg_memoria_pipe across depth and edge variants
module tb_reg_memoria_pipe;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;

  logic        in_ready_a, out_valid_a; logic [31:0] out_data_a; logic [1:0] count_a;
  logic        in_ready_b, out_valid_b; logic [31:0] out_data_b; logic [2:0] count_b;
  logic        in_ready_c, out_valid_c; logic [31:0] out_data_c; logic [1:0] count_c;
  logic        in_ready_e, out_valid_e; logic [31:0] out_data_e; logic [0:0] count_e;

  int n_pass = 0;
  int n_total = 0;

  int          mq_pos[$];
  logic [31:0] mq_data[$];

  always #5 clk = ~clk;

  reg_memoria_pipe #(.WIDTH(32), .DEPTH(3), .NEG_EDGE(1)) u_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
    .flush(flush), .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a), .count(count_a));
  reg_memoria_pipe #(.WIDTH(32), .DEPTH(4), .NEG_EDGE(1)) u_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
    .flush(flush), .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b), .count(count_b));
  reg_memoria_pipe #(.WIDTH(32), .DEPTH(2), .NEG_EDGE(1)) u_c (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_c), .in_data(in_data),
    .flush(flush), .out_valid(out_valid_c), .out_ready(out_ready), .out_data(out_data_c), .count(count_c));
  reg_memoria_pipe #(.WIDTH(32), .DEPTH(1), .NEG_EDGE(0)) u_e (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_e), .in_data(in_data),
    .flush(flush), .out_valid(out_valid_e), .out_ready(out_ready), .out_data(out_data_e), .count(count_e));

  // Word-position model: every word advances one slot per edge toward the
  // output unless the slot ahead is still taken; the head leaves on a pop.
  function automatic bit model_ready(input int depth, input bit ordy);
    int lim;
    lim = depth;
    for (int k = 0; k < mq_pos.size(); k++) begin
      int np;
      if (k == 0 && mq_pos[0] == depth - 1 && ordy) np = depth;
      else np = (mq_pos[k] + 1 < lim - 1) ? mq_pos[k] + 1 : lim - 1;
      lim = np;
    end
    return lim >= 1;
  endfunction

  task automatic model_step(input int depth, input bit iv, input logic [31:0] id,
                            input bit ordy, input bit fl);
    int lim;
    bit rdy;
    if (fl) begin
      mq_pos.delete();
      mq_data.delete();
      return;
    end
    lim = depth;
    for (int k = 0; k < mq_pos.size(); k++) begin
      int np;
      if (k == 0 && mq_pos[0] == depth - 1 && ordy) np = depth;
      else np = (mq_pos[k] + 1 < lim - 1) ? mq_pos[k] + 1 : lim - 1;
      mq_pos[k] = np;
      lim = np;
    end
    rdy = (lim >= 1);
    if (mq_pos.size() > 0 && mq_pos[0] == depth) begin
      void'(mq_pos.pop_front());
      void'(mq_data.pop_front());
    end
    if (iv && rdy) begin
      mq_pos.push_back(0);
      mq_data.push_back(id);
    end
  endtask

  task automatic nstep();
    @(negedge clk); #1;
  endtask

  task automatic pstep();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; in_data = '0;
    reset = 1'b1; #2;
    @(negedge clk); #3;
    reset = 1'b0; #1;
  endtask

  task automatic test_reset();
    #3;
    n_total++; if (out_valid_a !== 1'b0) $display("FAIL reset_out_valid_a got %b want 0", out_valid_a); else n_pass++;
    n_total++; if (out_data_a !== 32'h0) $display("FAIL reset_out_data_a got %h want 0", out_data_a); else n_pass++;
    n_total++; if (count_a !== 2'd0) $display("FAIL reset_count_a got %0d want 0", count_a); else n_pass++;
    n_total++; if (out_valid_e !== 1'b0) $display("FAIL reset_out_valid_e got %b want 0", out_valid_e); else n_pass++;
    n_total++; if (out_data_e !== 32'h0) $display("FAIL reset_out_data_e got %h want 0", out_data_e); else n_pass++;
  endtask

  task automatic test_single_word();
    do_reset();
    out_ready = 1'b1; in_valid = 1'b1; in_data = 32'hDEADBEEF; #1;
    n_total++; if (in_ready_a !== 1'b1) $display("FAIL single_in_ready got %b want 1", in_ready_a); else n_pass++;
    nstep(); in_valid = 1'b0; in_data = '0; #1;
    n_total++; if (out_valid_a !== 1'b0) $display("FAIL single_edge1_valid got %b want 0", out_valid_a); else n_pass++;
    n_total++; if (count_a !== 2'd1) $display("FAIL single_edge1_count got %0d want 1", count_a); else n_pass++;
    nstep();
    n_total++; if (out_valid_a !== 1'b0) $display("FAIL single_edge2_valid got %b want 0", out_valid_a); else n_pass++;
    nstep();
    n_total++; if (out_valid_a !== 1'b1) $display("FAIL single_edge3_valid got %b want 1", out_valid_a); else n_pass++;
    n_total++; if (out_data_a !== 32'hDEADBEEF) $display("FAIL single_edge3_data got %h want deadbeef", out_data_a); else n_pass++;
    nstep();
    n_total++; if (out_valid_a !== 1'b0) $display("FAIL single_pop_valid got %b want 0", out_valid_a); else n_pass++;
    n_total++; if (count_a !== 2'd0) $display("FAIL single_pop_count got %0d want 0", count_a); else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [31:0] got[$];
    logic acc;
    do_reset();
    out_ready = 1'b0;
    for (int w = 1; w <= 4; w++) begin
      in_valid = 1'b1; in_data = 32'(w); #1;
      n_total++;
      if (in_ready_a !== (w <= 3)) $display("FAIL bp_in_ready_word%0d got %b want %b", w, in_ready_a, (w <= 3));
      else n_pass++;
      nstep();
    end
    n_total++; if (count_a !== 2'd3) $display("FAIL bp_full_count got %0d want 3", count_a); else n_pass++;
    n_total++; if (out_data_a !== 32'd1) $display("FAIL bp_full_data got %h want 1", out_data_a); else n_pass++;
    nstep();
    n_total++; if (out_valid_a !== 1'b1 || out_data_a !== 32'd1) $display("FAIL bp_hold got %b/%h want 1/1", out_valid_a, out_data_a); else n_pass++;
    out_ready = 1'b1; #1;
    n_total++; if (in_ready_a !== 1'b1) $display("FAIL bp_full_ready_with_pop got %b want 1", in_ready_a); else n_pass++;
    for (int c = 0; c < 8; c++) begin
      if (out_valid_a === 1'b1) got.push_back(out_data_a);
      acc = in_valid && in_ready_a;
      nstep();
      if (acc) in_valid = 1'b0;
      #1;
      if (c == 0) begin
        n_total++; if (count_a !== 2'd3) $display("FAIL bp_push_pop_count got %0d want 3", count_a); else n_pass++;
      end
    end
    n_total++; if (got.size() != 4) $display("FAIL bp_drain_size got %0d want 4", got.size()); else n_pass++;
    for (int k = 0; k < got.size() && k < 4; k++) begin
      n_total++;
      if (got[k] !== 32'(k + 1)) $display("FAIL bp_drain_order%0d got %h want %h", k, got[k], k + 1);
      else n_pass++;
    end
    out_ready = 1'b0;
  endtask

  task automatic test_bubble();
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'hAAAA0001; #1;
    n_total++; if (in_ready_b !== 1'b1) $display("FAIL bubble_ready_a got %b want 1", in_ready_b); else n_pass++;
    nstep(); in_valid = 1'b0;
    nstep(); nstep();
    in_valid = 1'b1; in_data = 32'hBBBB0002; #1;
    n_total++; if (in_ready_b !== 1'b1) $display("FAIL bubble_ready_b got %b want 1", in_ready_b); else n_pass++;
    nstep(); in_valid = 1'b0;
    nstep(); nstep();
    n_total++; if (count_b !== 3'd2) $display("FAIL bubble_count got %0d want 2", count_b); else n_pass++;
    n_total++; if (out_valid_b !== 1'b1 || out_data_b !== 32'hAAAA0001) $display("FAIL bubble_head got %b/%h want 1/aaaa0001", out_valid_b, out_data_b); else n_pass++;
    out_ready = 1'b1; #1;
    nstep();
    n_total++; if (out_valid_b !== 1'b1 || out_data_b !== 32'hBBBB0002) $display("FAIL bubble_next got %b/%h want 1/bbbb0002", out_valid_b, out_data_b); else n_pass++;
    n_total++; if (count_b !== 3'd1) $display("FAIL bubble_count_after_pop got %0d want 1", count_b); else n_pass++;
    out_ready = 1'b0;
  endtask

  task automatic test_flush();
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h11; nstep();
    in_data = 32'h22; nstep();
    n_total++; if (count_c !== 2'd2) $display("FAIL flush_fill_count got %0d want 2", count_c); else n_pass++;
    n_total++; if (out_data_c !== 32'h11) $display("FAIL flush_fill_data got %h want 11", out_data_c); else n_pass++;
    flush = 1'b1; in_data = 32'h33; #1;
    n_total++; if (in_ready_c !== 1'b0) $display("FAIL flush_in_ready got %b want 0", in_ready_c); else n_pass++;
    nstep(); flush = 1'b0; in_valid = 1'b0; #1;
    n_total++; if (out_valid_c !== 1'b0) $display("FAIL flush_out_valid got %b want 0", out_valid_c); else n_pass++;
    n_total++; if (count_c !== 2'd0) $display("FAIL flush_count got %0d want 0", count_c); else n_pass++;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      nstep();
      n_total++; if (out_valid_c !== 1'b0) $display("FAIL flush_no_ghost%0d got %b/%h want 0", c, out_valid_c, out_data_c); else n_pass++;
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h1; nstep();
    in_data = 32'h2; nstep();
    in_valid = 1'b0; nstep();
    n_total++; if (count_a !== 2'd2 || out_valid_a !== 1'b1) $display("FAIL midrst_pre got %0d/%b want 2/1", count_a, out_valid_a); else n_pass++;
    #2; reset = 1'b1; #1;
    n_total++; if (out_valid_a !== 1'b0) $display("FAIL midrst_valid got %b want 0", out_valid_a); else n_pass++;
    n_total++; if (count_a !== 2'd0) $display("FAIL midrst_count got %0d want 0", count_a); else n_pass++;
    #3; reset = 1'b0;
    out_ready = 1'b1; in_valid = 1'b1; in_data = 32'h5;
    nstep(); in_valid = 1'b0;
    n_total++; if (out_valid_a !== 1'b0) $display("FAIL midrst_lat1 got %b want 0", out_valid_a); else n_pass++;
    nstep();
    n_total++; if (out_valid_a !== 1'b0) $display("FAIL midrst_lat2 got %b want 0", out_valid_a); else n_pass++;
    nstep();
    n_total++; if (out_valid_a !== 1'b1 || out_data_a !== 32'h5) $display("FAIL midrst_lat3 got %b/%h want 1/5", out_valid_a, out_data_a); else n_pass++;
    out_ready = 1'b0;
  endtask

  task automatic test_edge_mode();
    do_reset();
    out_ready = 1'b0;
    pstep();
    in_valid = 1'b1; in_data = 32'hA5A5A5A5; #1;
    n_total++; if (in_ready_e !== 1'b1) $display("FAIL edge_in_ready got %b want 1", in_ready_e); else n_pass++;
    @(negedge clk); #1;
    n_total++; if (out_valid_e !== 1'b0) $display("FAIL edge_no_fall_capture got %b want 0", out_valid_e); else n_pass++;
    pstep();
    n_total++; if (out_valid_e !== 1'b1 || out_data_e !== 32'hA5A5A5A5) $display("FAIL edge_rise_capture got %b/%h want 1/a5a5a5a5", out_valid_e, out_data_e); else n_pass++;
    in_data = 32'h1; #1;
    n_total++; if (in_ready_e !== 1'b0) $display("FAIL edge_full_stalled_ready got %b want 0", in_ready_e); else n_pass++;
    out_ready = 1'b1; #1;
    n_total++; if (in_ready_e !== 1'b1) $display("FAIL edge_full_pop_ready got %b want 1", in_ready_e); else n_pass++;
    pstep(); in_valid = 1'b0;
    n_total++; if (count_e !== 1'b1 || out_data_e !== 32'h1 || out_valid_e !== 1'b1) $display("FAIL edge_push_pop got %0d/%h want 1/1", count_e, out_data_e); else n_pass++;
    pstep();
    n_total++; if (count_e !== 1'b0 || out_valid_e !== 1'b0) $display("FAIL edge_drain got %0d/%b want 0/0", count_e, out_valid_e); else n_pass++;
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    bit          iv, ordy, fl, exp_rdy, exp_v;
    logic [31:0] id;
    do_reset();
    mq_pos.delete();
    mq_data.delete();
    for (int c = 0; c < 400; c++) begin
      iv   = ($urandom % 4) != 0;
      id   = $urandom;
      ordy = ($urandom % 100) < ((c < 200) ? 30 : 80);
      fl   = ($urandom % 30) == 0;
      in_valid = iv; in_data = id; out_ready = ordy; flush = fl; #1;
      exp_rdy = model_ready(3, ordy) && !fl;
      exp_v   = (mq_pos.size() > 0) && (mq_pos[0] == 2);
      n_total++; if (in_ready_a !== exp_rdy) $display("FAIL rand%0d_in_ready got %b want %b", c, in_ready_a, exp_rdy); else n_pass++;
      n_total++; if (out_valid_a !== exp_v) $display("FAIL rand%0d_out_valid got %b want %b", c, out_valid_a, exp_v); else n_pass++;
      n_total++; if (count_a !== 2'(mq_pos.size())) $display("FAIL rand%0d_count got %0d want %0d", c, count_a, mq_pos.size()); else n_pass++;
      if (exp_v) begin
        n_total++; if (out_data_a !== mq_data[0]) $display("FAIL rand%0d_out_data got %h want %h", c, out_data_a, mq_data[0]); else n_pass++;
      end
      model_step(3, iv, id, ordy, fl);
      nstep();
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_word();
    test_backpressure();
    test_bubble();
    test_flush();
    test_reset_mid();
    test_edge_mode();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
